// File: rtl/x2821_pkg.sv
// Shared constants and types for the x2821 print path: EBCDIC code points,
// printer BCD bit weights, and the lookup result payload.
package x2821_pkg;

  localparam int unsigned EBCDIC_W = 8;
  localparam int unsigned BCD_W    = 6;

  // Printer BCD bit weights (B A 8 4 2 1).
  localparam logic [BCD_W-1:0] BCD_B     = 6'o40;
  localparam logic [BCD_W-1:0] BCD_A     = 6'o20;
  localparam logic [BCD_W-1:0] BCD_BLANK = 6'o00;
  localparam logic [BCD_W-1:0] BCD_ZERO  = 6'o12;

  localparam logic [EBCDIC_W-1:0] E_SP = 8'h40;
  localparam logic [EBCDIC_W-1:0] E_NL = 8'h15;
  localparam logic [EBCDIC_W-1:0] E_0  = 8'hF0;
  localparam logic [EBCDIC_W-1:0] E_A  = 8'hC1;
  localparam logic [EBCDIC_W-1:0] E_a  = 8'h81;

  typedef struct packed {
    logic [BCD_W-1:0] bcd;
    logic             space;
    logic             unassigned;
  } lut_out_t;

  localparam lut_out_t LUT_UNASSIGNED = '{bcd: BCD_BLANK, space: 1'b0, unassigned: 1'b1};
  localparam lut_out_t LUT_SPACE      = '{bcd: BCD_BLANK, space: 1'b1, unassigned: 1'b0};

  // Wrap a printable BCD code as a lookup result.
  function automatic lut_out_t lut_printable(input logic [BCD_W-1:0] code);
    lut_printable = '{bcd: code, space: 1'b0, unassigned: 1'b0};
  endfunction

endpackage

// File: rtl/ebcdic_bcd_lut.sv
// Combinational EBCDIC -> printer BCD translation: zone/digit decode for the
// alphanumerics, explicit list for punctuation, everything else unassigned.
module ebcdic_bcd_lut
  import x2821_pkg::*;
(
  input  logic [EBCDIC_W-1:0] i_ebcdic,
  output lut_out_t            o_lut
);

  logic [3:0]       zone;
  logic [3:0]       digit;
  logic             digit_1_9;
  logic             digit_2_9;
  logic [BCD_W-1:0] digit_bcd;

  assign zone      = i_ebcdic[7:4];
  assign digit     = i_ebcdic[3:0];
  assign digit_1_9 = (digit >= 4'd1) && (digit <= 4'd9);
  assign digit_2_9 = (digit >= 4'd2) && (digit <= 4'd9);
  assign digit_bcd = BCD_W'(digit);

  always_comb begin
    o_lut = LUT_UNASSIGNED;

    // Upper and lower case share a zone; S..Z start at digit 2.
    unique case (zone)
      4'hC, 4'h8: if (digit_1_9) o_lut = lut_printable(BCD_B | BCD_A | digit_bcd);
      4'hD, 4'h9: if (digit_1_9) o_lut = lut_printable(BCD_B | digit_bcd);
      4'hE, 4'hA: if (digit_2_9) o_lut = lut_printable(BCD_A | digit_bcd);
      4'hF: begin
        if (i_ebcdic == E_0)  o_lut = lut_printable(BCD_ZERO);
        else if (digit_1_9)   o_lut = lut_printable(digit_bcd);
      end
      default: ;
    endcase

    // Punctuation and space; none of these collide with the zone decode.
    case (i_ebcdic)
      E_SP:  o_lut = LUT_SPACE;
      8'h61: o_lut = lut_printable(BCD_A | 6'o01);
      8'h60: o_lut = lut_printable(BCD_B);
      8'h50,
      8'h4E: o_lut = lut_printable(BCD_B | BCD_A);
      8'h4B: o_lut = lut_printable(6'o73);
      8'h4C,
      8'h5D: o_lut = lut_printable(6'o74);
      8'h5B: o_lut = lut_printable(6'o53);
      8'h5C: o_lut = lut_printable(6'o54);
      8'h6B: o_lut = lut_printable(6'o33);
      8'h6C,
      8'h4D: o_lut = lut_printable(6'o34);
      8'h7B,
      8'h7E: o_lut = lut_printable(6'o13);
      8'h7C,
      8'h7D: o_lut = lut_printable(6'o14);
      default: ;
    endcase
  end

endmodule

// File: rtl/ebcdic_to_bcd_pipe.sv
// EBCDIC to printer BCD translator with a fixed DELAY-stage register pipeline
// between the channel buffer and the print-line compare logic.
module ebcdic_to_bcd_pipe
  import x2821_pkg::*;
#(
  parameter int unsigned DELAY = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [EBCDIC_W-1:0] i_ebcdic,
  output logic [BCD_W-1:0]    o_bcd,
  output logic                o_space,
  output logic                o_unassigned
);

  lut_out_t lut_c;
  lut_out_t pipe_d [DELAY];
  lut_out_t pipe_q [DELAY];

  ebcdic_bcd_lut u_lut (
    .i_ebcdic (i_ebcdic),
    .o_lut    (lut_c)
  );

  always_comb begin
    pipe_d[0] = lut_c;
    for (int unsigned i = 1; i < DELAY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Reset clears every stage so in-flight characters are discarded.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign o_bcd        = pipe_q[DELAY-1].bcd;
  assign o_space      = pipe_q[DELAY-1].space;
  assign o_unassigned = pipe_q[DELAY-1].unassigned;

endmodule

// File: tb/tb_ebcdic_to_bcd_pipe.sv
// Directed bench for ebcdic_to_bcd_pipe: a scoreboard queue holds expected
// {bcd, space, unassigned} per driven character, popped DELAY clocks later.
module tb_ebcdic_to_bcd_pipe;

  localparam int unsigned DELAY = 3;

  logic       i_clk;
  logic       i_reset;
  logic [7:0] i_ebcdic;
  logic [5:0] o_bcd;
  logic       o_space;
  logic       o_unassigned;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] tag_q [$];

  ebcdic_to_bcd_pipe #(.DELAY(DELAY)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_ebcdic     (i_ebcdic),
    .o_bcd        (o_bcd),
    .o_space      (o_space),
    .o_unassigned (o_unassigned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference table: {bcd[5:0], space, unassigned}.
  function automatic logic [7:0] ref_of(input logic [7:0] e);
    logic [5:0] b;
    b = 6'o00;
    case (e)
      8'h40: return {6'o00, 1'b1, 1'b0};
      8'hF0: b = 6'o12;
      8'hF1: b = 6'o01; 8'hF2: b = 6'o02; 8'hF3: b = 6'o03;
      8'hF4: b = 6'o04; 8'hF5: b = 6'o05; 8'hF6: b = 6'o06;
      8'hF7: b = 6'o07; 8'hF8: b = 6'o10; 8'hF9: b = 6'o11;
      8'hC1, 8'h81: b = 6'o61; 8'hC4, 8'h84: b = 6'o64; 8'hC9, 8'h89: b = 6'o71;
      8'hD1, 8'h91: b = 6'o41; 8'hD8, 8'h98: b = 6'o50; 8'hD9, 8'h99: b = 6'o51;
      8'hE2, 8'hA2: b = 6'o22; 8'hE7, 8'hA7: b = 6'o27; 8'hE9, 8'hA9: b = 6'o31;
      8'h61: b = 6'o21; 8'h60: b = 6'o40; 8'h50: b = 6'o60; 8'h4E: b = 6'o60;
      8'h4B: b = 6'o73; 8'h4C: b = 6'o74; 8'h5D: b = 6'o74;
      8'h5B: b = 6'o53; 8'h5C: b = 6'o54;
      8'h6B: b = 6'o33; 8'h6C: b = 6'o34; 8'h4D: b = 6'o34;
      8'h7B: b = 6'o13; 8'h7E: b = 6'o13; 8'h7C: b = 6'o14; 8'h7D: b = 6'o14;
      default: return {6'o00, 1'b0, 1'b1};
    endcase
    return {b, 1'b0, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [7:0] code,
                     input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s char=%h observed bcd=%o sp=%b un=%b expected bcd=%o sp=%b un=%b",
             tag, code, obs[7:2], obs[1], obs[0], expv[7:2], expv[1], expv[0]);
    end
  endtask

  // Called at a falling edge: check the head of the scoreboard (or the
  // cleared pipeline while it refills), drive the next char, advance.
  task automatic cycle(input logic [7:0] e);
    logic [7:0] expv;
    logic [7:0] tag;
    if (exp_q.size() == DELAY) begin
      expv = exp_q.pop_front();
      tag  = tag_q.pop_front();
      chk("data", tag, {o_bcd, o_space, o_unassigned}, expv);
    end else begin
      chk("fill_zero", 8'h00, {o_bcd, o_space, o_unassigned}, 8'h00);
    end
    i_ebcdic = e;
    exp_q.push_back(ref_of(e));
    tag_q.push_back(e);
    @(negedge i_clk);
  endtask

  logic [7:0] seq_a [] = '{8'hF0, 8'h15, 8'h40, 8'hC1, 8'h81, 8'hF1, 8'h61, 8'hE7,
                          8'h98, 8'hC4, 8'h7B, 8'h7C, 8'h6C, 8'h4C, 8'h7E, 8'h7D,
                          8'h4D, 8'h5D, 8'h4B, 8'h5B, 8'h5C, 8'h50, 8'h4E, 8'h60,
                          8'h6B, 8'hE1, 8'hA1, 8'hFF, 8'h00, 8'hFA, 8'hA9, 8'hD9};
  logic [7:0] seq_b [] = '{8'hF5, 8'hC9, 8'hE2, 8'h40, 8'h15, 8'hF9, 8'h00, 8'h00, 8'h00};

  initial begin
    i_reset  = 1'b1;
    i_ebcdic = 8'hF0;
    repeat (2) begin
      @(negedge i_clk);
      chk("reset_hold", i_ebcdic, {o_bcd, o_space, o_unassigned}, 8'h00);
    end
    i_reset = 1'b0;

    foreach (seq_a[i]) cycle(seq_a[i]);

    // Asynchronous reset between edges: outputs must clear without a clock.
    @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1 chk("async_reset", 8'h00, {o_bcd, o_space, o_unassigned}, 8'h00);
    exp_q.delete();
    tag_q.delete();
    @(negedge i_clk);
    chk("reset_mid", 8'h00, {o_bcd, o_space, o_unassigned}, 8'h00);
    @(negedge i_clk);
    i_reset = 1'b0;

    foreach (seq_b[i]) cycle(seq_b[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
